// File: rtl/rmw_long_latency_pkg.sv
// rtl/rmw_long_latency_pkg.sv - shared types and helpers for the RMW long-latency pipeline
// Purpose: command encoding (op_t, issue_t) plus the in-flight scheduler slot types
//          and one-hot pointer helpers used by rmw_lkup_sched.
package rmw_long_latency_pkg;

    typedef enum logic [1:0] {
        OP_ADDI = 2'd0,
        OP_SUBI = 2'd1,
        OP_NOP  = 2'd2,
        OP_MOVI = 2'd3
    } op_t;

    typedef struct packed {
        logic [15:0] id;
        logic [31:0] imm;
        op_t         op;
    } issue_t;

    function automatic logic op_requires_tbl_lkup(input op_t op);
        return (op != OP_MOVI);
    endfunction

    localparam int IN_FLIGHT_N = 16;
    localparam int SCHED_TAG_W = $clog2(IN_FLIGHT_N);

    typedef logic [SCHED_TAG_W-1:0] sched_tag_t;
    typedef logic [IN_FLIGHT_N-1:0] sched_ptr_t;

    typedef enum logic [1:0] {
        FREE        = 2'd0,
        AWAIT_ISSUE = 2'd1,
        AWAIT_RSP   = 2'd2,
        COMPLETE    = 2'd3
    } sched_state_t;

    typedef struct packed {
        sched_state_t state;
        issue_t       issue;
        logic [31:0]  word;
    } sched_slot_t;

    // One-hot rotate towards the next-younger slot, wrapping at the top.
    function automatic sched_ptr_t advance_ptr(input sched_ptr_t ptr);
        return {ptr[IN_FLIGHT_N-2:0], ptr[IN_FLIGHT_N-1]};
    endfunction

    function automatic sched_tag_t enc_ptr(input sched_ptr_t ptr);
        sched_tag_t tag;
        tag = '0;
        for (int i = 0; i < IN_FLIGHT_N; i++) begin
            if (ptr[i]) begin
                tag = tag | sched_tag_t'(i);
            end
        end
        return tag;
    endfunction

endpackage

// File: rtl/rmw_lkup_sched_alu.sv
// rtl/rmw_lkup_sched_alu.sv - applies the RMW op to a table word
// Ports: word (table word), imm (command immediate), op -> result (modulo 2^32).
module rmw_lkup_sched_alu
    import rmw_long_latency_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] imm,
    input  op_t         op,
    output logic [31:0] result
);

    always_comb begin
        result = word;
        case (op)
            OP_ADDI: result = word + imm;
            OP_SUBI: result = word - imm;
            OP_NOP:  result = word;
            OP_MOVI: result = imm;
            default: result = word;
        endcase
    end

endmodule

// File: rtl/rmw_lkup_sched.sv
// rtl/rmw_lkup_sched.sv - in-order TBL lookup scheduler with RAW hazard stall
// Ports: cmd_* accepts issue_t commands; lkup_* issues TBL lookups in age order;
//        rsp_* returns table words by tag; out_* retires results in allocation order;
//        stall_cnt counts hazard stalls when RMW_LKUP_SCHED_STALL_CNT_EN is defined
//        (tied to 0 otherwise).
// IN_FLIGHT_N must match the package value, which sizes the slot/pointer types.
module rmw_lkup_sched #(
    parameter  int IN_FLIGHT_N = rmw_long_latency_pkg::IN_FLIGHT_N,
    localparam int TAG_W       = $clog2(IN_FLIGHT_N)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_vld,
    input  rmw_long_latency_pkg::issue_t cmd_issue,
    output logic                         cmd_accept,
    output logic                         lkup_vld,
    output logic [15:0]                  lkup_id,
    output logic [TAG_W-1:0]             lkup_tag,
    input  logic                         lkup_accept,
    input  logic                         rsp_vld,
    input  logic [TAG_W-1:0]             rsp_tag,
    input  logic [31:0]                  rsp_word,
    output logic                         out_vld,
    output logic [15:0]                  out_id,
    output logic [31:0]                  out_word,
    input  logic                         out_accept,
    output logic [31:0]                  stall_cnt
);
    import rmw_long_latency_pkg::*;

    sched_slot_t slots [IN_FLIGHT_N];
    sched_ptr_t  alloc_ptr, issue_ptr, retire_ptr;
    sched_tag_t  alloc_tag, issue_tag, retire_tag;
    logic        full, id_match, hazard;
    logic        lkup_fire, issue_skip, rsp_hit, retire_fire;
    logic [31:0] rsp_result;

    assign alloc_tag  = enc_ptr(alloc_ptr);
    assign issue_tag  = enc_ptr(issue_ptr);
    assign retire_tag = enc_ptr(retire_ptr);

    // Buffer is strictly in order, so the alloc slot being busy means all slots are busy.
    assign full = (slots[alloc_tag].state != FREE);

    // Registered state only: a slot retiring this cycle still blocks a matching id.
    always_comb begin
        id_match = 1'b0;
        for (int i = 0; i < IN_FLIGHT_N; i++) begin
            if (slots[i].state != FREE && slots[i].issue.id == cmd_issue.id) begin
                id_match = 1'b1;
            end
        end
    end

    assign hazard     = op_requires_tbl_lkup(cmd_issue.op) && id_match;
    assign cmd_accept = !rst && cmd_vld && !full && !hazard;

    assign lkup_vld   = (slots[issue_tag].state == AWAIT_ISSUE);
    assign lkup_id    = slots[issue_tag].issue.id;
    assign lkup_tag   = issue_tag;
    assign lkup_fire  = lkup_vld && lkup_accept;
    // MOVI slots are already complete; the issue pointer steps over them.
    assign issue_skip = (slots[issue_tag].state == COMPLETE);

    assign rsp_hit    = rsp_vld && (slots[rsp_tag].state == AWAIT_RSP);

    assign out_vld     = (slots[retire_tag].state == COMPLETE);
    assign out_id      = slots[retire_tag].issue.id;
    assign out_word    = slots[retire_tag].word;
    assign retire_fire = out_vld && out_accept;

    rmw_lkup_sched_alu u_alu (
        .word   (rsp_word),
        .imm    (slots[rsp_tag].issue.imm),
        .op     (slots[rsp_tag].issue.op),
        .result (rsp_result)
    );

    // Alloc, issue, response and retire each require a different slot state,
    // so the four updates below never collide on one slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < IN_FLIGHT_N; i++) begin
                slots[i] <= '0;
            end
            alloc_ptr  <= sched_ptr_t'(1);
            issue_ptr  <= sched_ptr_t'(1);
            retire_ptr <= sched_ptr_t'(1);
        end else begin
            if (cmd_accept) begin
                slots[alloc_tag].issue <= cmd_issue;
                slots[alloc_tag].word  <= cmd_issue.imm;
                if (op_requires_tbl_lkup(cmd_issue.op)) begin
                    slots[alloc_tag].state <= AWAIT_ISSUE;
                end else begin
                    slots[alloc_tag].state <= COMPLETE;
                end
                alloc_ptr <= advance_ptr(alloc_ptr);
            end
            if (lkup_fire) begin
                slots[issue_tag].state <= AWAIT_RSP;
                issue_ptr <= advance_ptr(issue_ptr);
            end else if (issue_skip) begin
                issue_ptr <= advance_ptr(issue_ptr);
            end
            if (rsp_hit) begin
                slots[rsp_tag].state <= COMPLETE;
                slots[rsp_tag].word  <= rsp_result;
            end
            if (retire_fire) begin
                slots[retire_tag].state <= FREE;
                retire_ptr <= advance_ptr(retire_ptr);
            end
        end
    end

`ifdef RMW_LKUP_SCHED_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (cmd_vld && !full && hazard && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

    rsp_targets_pending_slot: assert property (
        @(posedge clk) disable iff (rst) rsp_vld |-> (slots[rsp_tag].state == AWAIT_RSP)
    );

endmodule

// File: tb/tb_rmw_lkup_sched.sv
// tb/tb_rmw_lkup_sched.sv - randomized scoreboard bench for rmw_lkup_sched
module tb_rmw_lkup_sched;
    import rmw_long_latency_pkg::*;

    typedef struct {
        logic [15:0] id;
        logic [31:0] word;
    } exp_t;

    typedef struct {
        logic [3:0]  tag;
        logic [15:0] id;
    } lk_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_vld = 1'b0;
    issue_t      cmd_issue = '0;
    logic        cmd_accept;
    logic        lkup_vld;
    logic [15:0] lkup_id;
    logic [3:0]  lkup_tag;
    logic        lkup_accept = 1'b0;
    logic        rsp_vld = 1'b0;
    logic [3:0]  rsp_tag = '0;
    logic [31:0] rsp_word = '0;
    logic        out_vld;
    logic [15:0] out_id;
    logic [31:0] out_word;
    logic        out_accept = 1'b0;
    logic [31:0] stall_cnt;

    rmw_lkup_sched #(.IN_FLIGHT_N(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_vld     (cmd_vld),
        .cmd_issue   (cmd_issue),
        .cmd_accept  (cmd_accept),
        .lkup_vld    (lkup_vld),
        .lkup_id     (lkup_id),
        .lkup_tag    (lkup_tag),
        .lkup_accept (lkup_accept),
        .rsp_vld     (rsp_vld),
        .rsp_tag     (rsp_tag),
        .rsp_word    (rsp_word),
        .out_vld     (out_vld),
        .out_id      (out_id),
        .out_word    (out_word),
        .out_accept  (out_accept),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    exp_t        exp_q[$];
    lk_t         iss_q[$];
    lk_t         pend[$];
    logic [31:0] tbl [256];
    logic [3:0]  tag_ctr;
    int          n_checks = 0;
    int          n_fail = 0;
    int          stall_model = 0;

    int          rsp_mode = 0;       // 0 random, 1 hold, 2 newest-first every cycle
    int          lkup_acc_pct = 100;
    int          out_acc_pct = 100;
    bit          tbl_inj = 1'b0;
    logic [3:0]  inj_tag = '0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
        end
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        iss_q.delete();
        pend.delete();
        tag_ctr     = '0;
        stall_model = 0;
    endfunction

    function automatic void model_push(input op_t op, input logic [15:0] id, input logic [31:0] imm);
        logic [31:0] base;
        logic [31:0] w;
        base = tbl[id[7:0]];
        case (op)
            OP_ADDI: w = base + imm;
            OP_SUBI: w = base - imm;
            OP_NOP:  w = base;
            default: w = imm;
        endcase
        exp_q.push_back('{id, w});
        if (op != OP_MOVI) iss_q.push_back('{tag_ctr, id});
        tag_ctr = tag_ctr + 4'd1;
    endfunction

    task automatic send(input op_t op, input logic [15:0] id, input logic [31:0] imm, input int budget);
        issue_t c;
        bit     hz;
        bit     exp_acc;
        bit     done;
        c.op = op;
        c.id = id;
        c.imm = imm;
        done = 1'b0;
        for (int n = 0; n < budget && !done; n++) begin
            @(negedge clk);
            cmd_vld   = 1'b1;
            cmd_issue = c;
            #1;
            hz = 1'b0;
            if (op != OP_MOVI) begin
                foreach (exp_q[i]) if (exp_q[i].id == id) hz = 1'b1;
            end
            exp_acc = (exp_q.size() < 16) && !hz;
            if (exp_q.size() < 16 && hz) stall_model++;
            check("cmd_accept", {31'd0, cmd_accept}, {31'd0, exp_acc});
            if (cmd_accept === 1'b1) begin
                model_push(op, id, imm);
                done = 1'b1;
            end
        end
        if (!done) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        cmd_vld = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int n = 0; n < budget && (exp_q.size() != 0 || pend.size() != 0); n++) begin
            @(negedge clk);
        end
        check("drain_empty", exp_q.size(), 32'd0);
    endtask

    // Table model: accepts lookups, checks them against age order, answers later.
    initial begin : tbl_proc
        int  k;
        lk_t e;
        forever begin
            @(negedge clk);
            #2;
            rsp_vld = 1'b0;
            k = -1;
            if (tbl_inj) begin
                rsp_vld  = 1'b1;
                rsp_tag  = inj_tag;
                rsp_word = 32'hDEAD_BEEF;
            end else if (pend.size() > 0 && rsp_mode != 1) begin
                if (rsp_mode == 2) k = pend.size() - 1;
                else if ($urandom_range(99) < 50) k = int'($urandom_range(pend.size() - 1));
                if (k >= 0) begin
                    rsp_vld  = 1'b1;
                    rsp_tag  = pend[k].tag;
                    rsp_word = tbl[pend[k].id[7:0]];
                    pend.delete(k);
                end
            end
            lkup_accept = ($urandom_range(99) < lkup_acc_pct);
            if (lkup_vld && lkup_accept) begin
                if (iss_q.size() == 0) begin
                    check("lkup_unexpected", {31'd0, lkup_vld}, 32'd0);
                end else begin
                    e = iss_q.pop_front();
                    check("lkup_tag", {28'd0, lkup_tag}, {28'd0, e.tag});
                    check("lkup_id", {16'd0, lkup_id}, {16'd0, e.id});
                    pend.push_back(e);
                end
            end
        end
    end

    // Retire monitor: every accepted result must match the oldest expectation.
    initial begin : mon_proc
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            out_accept = ($urandom_range(99) < out_acc_pct);
            if (out_vld && out_accept) begin
                if (exp_q.size() == 0) begin
                    check("out_unexpected", {31'd0, out_vld}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_id", {16'd0, out_id}, {16'd0, e.id});
                    check("out_word", out_word, e.word);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main_proc
        op_t op;
        for (int i = 0; i < 256; i++) tbl[i] = $urandom;
        tbl[3] = 32'hFFFF_FFFF;
        model_reset();

        // Reset state, including cmd_accept gating while rst is high.
        cmd_vld   = 1'b1;
        cmd_issue = '{id: 16'd1, imm: 32'd0, op: OP_ADDI};
        @(negedge clk);
        #1;
        check("rst_cmd_accept", {31'd0, cmd_accept}, 32'd0);
        check("rst_lkup_vld", {31'd0, lkup_vld}, 32'd0);
        check("rst_out_vld", {31'd0, out_vld}, 32'd0);
        check("rst_stall_cnt", stall_cnt, 32'd0);
        cmd_vld = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // ADDI with wrapping add; first lookup carries tag 0 one cycle after accept.
        send(OP_ADDI, 16'd3, 32'd2, 20);
        check("addi_lkup_vld", {31'd0, lkup_vld}, 32'd1);
        check("addi_lkup_id", {16'd0, lkup_id}, 32'd3);
        check("addi_lkup_tag", {28'd0, lkup_tag}, 32'd0);
        drain(200);

        // MOVI into an idle buffer retires one cycle later without a lookup.
        send(OP_MOVI, 16'd5, 32'h10, 20);
        check("movi_out_vld", {31'd0, out_vld}, 32'd1);
        check("movi_out_id", {16'd0, out_id}, 32'd5);
        check("movi_out_word", out_word, 32'h10);
        check("movi_lkup_vld", {31'd0, lkup_vld}, 32'd0);
        drain(50);

        // Same-id RAW hazard: second command stalls until the first retires.
        send(OP_ADDI, 16'd7, 32'd9, 20);
        send(OP_SUBI, 16'd7, 32'd4, 300);
        drain(300);

        // Fill all 16 slots, 17th stalls; responses released newest first.
        rsp_mode = 1;
        for (int i = 0; i < 16; i++) send(OP_ADDI, 16'(100 + i), $urandom, 40);
        fork
            send(OP_ADDI, 16'd116, 32'd5, 400);
            begin
                repeat (6) @(negedge clk);
                rsp_mode = 2;
            end
        join
        rsp_mode = 0;
        drain(400);

        // MOVI between NOPs with lookups blocked: MOVI waits behind the older NOP.
        lkup_acc_pct = 0;
        send(OP_NOP, 16'd20, 32'd0, 20);
        send(OP_MOVI, 16'd21, 32'hA5A5_0021, 20);
        send(OP_NOP, 16'd22, 32'd0, 20);
        repeat (4) @(negedge clk);
        #1;
        check("ilv_out_vld", {31'd0, out_vld}, 32'd0);
        check("ilv_lkup_vld", {31'd0, lkup_vld}, 32'd1);
        check("ilv_lkup_id", {16'd0, lkup_id}, 32'd20);
        lkup_acc_pct = 100;
        drain(300);

        // Reset with 8 slots in flight and a stale response for tag 2.
        rsp_mode = 1;
        for (int i = 0; i < 8; i++) send(OP_ADDI, 16'(40 + i), 32'(i), 40);
        repeat (12) @(negedge clk);
        rst = 1'b1;
        model_reset();
        tbl_inj   = 1'b1;
        inj_tag   = 4'd2;
        cmd_vld   = 1'b1;
        cmd_issue = '{id: 16'd60, imm: 32'd0, op: OP_MOVI};
        #1;
        check("mid_rst_cmd_accept", {31'd0, cmd_accept}, 32'd0);
        check("mid_rst_lkup_vld", {31'd0, lkup_vld}, 32'd0);
        check("mid_rst_out_vld", {31'd0, out_vld}, 32'd0);
        check("mid_rst_stall_cnt", stall_cnt, 32'd0);
        @(negedge clk);
        cmd_vld  = 1'b0;
        tbl_inj  = 1'b0;
        rst      = 1'b0;
        rsp_mode = 0;
        send(OP_ADDI, 16'd50, 32'd7, 20);
        check("post_rst_lkup_vld", {31'd0, lkup_vld}, 32'd1);
        check("post_rst_lkup_tag", {28'd0, lkup_tag}, 32'd0);
        check("post_rst_lkup_id", {16'd0, lkup_id}, 32'd50);
        drain(300);

        // Random traffic over a small id range to provoke hazards and backpressure.
        lkup_acc_pct = 70;
        out_acc_pct  = 70;
        for (int i = 0; i < 200; i++) begin
            op = op_t'($urandom_range(3));
            send(op, 16'($urandom_range(7)), $urandom, 400);
            if ($urandom_range(3) == 0) @(negedge clk);
        end
        out_acc_pct = 100;
        drain(3000);

`ifdef RMW_LKUP_SCHED_STALL_CNT_EN
        check("stall_cnt", stall_cnt, 32'(stall_model));
`else
        check("stall_cnt", stall_cnt, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rmw_lkup_sched.md
Name: rmw_lkup_sched

Overview:
- In-order scheduler that sits between the command front-end and the long-latency table (TBL) in the RMW pipeline.
- Accepts issue_t commands and allocates each one an in-flight slot and tag, then issues TBL lookups in age order.
- Applies the op (ADDI/SUBI/NOP/MOVI) to the returned word and retires results strictly in allocation order.
- Stalls any command needing a lookup while an older in-flight command to the same id is still unretired (read-after-write hazard).

Parameters:
- IN_FLIGHT_N, 16, number of in-flight slots; must be a power of two and at least 2.
- TAG_W, $clog2(IN_FLIGHT_N), tag width; derived, not overridden.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- cmd_vld  in  1  command valid
- cmd_issue  in  $bits(issue_t)  command {id, imm, op}
- cmd_accept  out  1  command taken this cycle
- lkup_vld  out  1  TBL lookup request valid
- lkup_id  out  16  id to look up
- lkup_tag  out  TAG_W  slot tag for the lookup
- lkup_accept  in  1  TBL took the request
- rsp_vld  in  1  TBL response valid
- rsp_tag  in  TAG_W  tag of the response
- rsp_word  in  32  table word
- out_vld  out  1  retired result valid
- out_id  out  16  result id
- out_word  out  32  result word (write-back value)
- out_accept  in  1  consumer took the result
- stall_cnt  out  32  hazard-stall cycle count (see Optional Feature)

Behaviour:
- Reset: all slots invalid; alloc, issue and retire pointers at slot 0 (one-hot 'b1). cmd_accept=0, lkup_vld=0, out_vld=0, stall_cnt=0 while rst is high. Reset mid-operation discards all in-flight slots; late TBL responses after reset are ignored.
- Slot state: FREE -> AWAIT_ISSUE -> AWAIT_RSP -> COMPLETE -> FREE.
  - MOVI allocates directly into COMPLETE with word = imm.
- Accept rule: cmd_accept = cmd_vld & !full & !hazard.
  - full: the slot at the alloc pointer is not FREE. There is no same-cycle bypass of a retire into a full buffer.
  - hazard: op_requires_tbl_lkup(op) and any non-FREE slot holds the same id. The compare uses registered slot state, so a retiring matching slot still stalls that cycle.
- Allocation: on accept, the slot at the alloc pointer is written at the clock edge and the alloc pointer advances with wrap via advance_ptr. Tag = enc_ptr(slot).
- Issue pointer: walks slots in age order.
  - Slot is AWAIT_ISSUE: drive lkup_vld=1, lkup_id, lkup_tag. On lkup_accept, move the slot to AWAIT_RSP and advance the pointer.
  - Slot is COMPLETE (MOVI): advance without issuing, one slot per cycle.
  - Slot is FREE: hold.
  - lkup_vld and its payload are stable until accepted.
- Response: rsp_vld with rsp_tag on an AWAIT_RSP slot registers word and sets COMPLETE next cycle.
  - ADDI: word = rsp_word + imm.
  - SUBI: word = rsp_word - imm.
  - NOP: word = rsp_word.
  - All arithmetic is modulo 2^32.
  - A response to a non-AWAIT_RSP slot is a protocol error: ignored, and an SVA fires.
- Retire: out_vld = retire slot is COMPLETE; out_id/out_word come from that slot. On out_accept the slot goes FREE and the retire pointer advances. Payload is stable while out_vld & !out_accept.
- Latency:
  - MOVI into an empty buffer: accept at cycle 0, out_vld at cycle 1.
  - Lookup: lkup_vld earliest at cycle 1; a response at cycle t gives out_vld at t+1 if that slot is the oldest.
- Simultaneous events: accept, lookup handshake, response and retire may all occur in one cycle on distinct slots. A response and a retire can never target the same slot.

Optional Feature:
- Macro: RMW_LKUP_SCHED_STALL_CNT_EN.
- Defined: stall_cnt increments (saturating at 2^32-1) on every cycle with cmd_vld & !full & hazard.
- Undefined: the counter logic is absent and stall_cnt is tied to 0.

Decomposition:
- Add to rmw_long_latency_pkg:
  - IN_FLIGHT_N, sched_tag_t, sched_ptr_t
  - sched_state_t (FREE/AWAIT_ISSUE/AWAIT_RSP/COMPLETE)
  - sched_slot_t {state, issue, word}
  - one-hot advance/encode helpers sized to IN_FLIGHT_N
- Reuse the existing issue_t, op_t and op_requires_tbl_lkup.
- One sub-module: rmw_lkup_sched_alu (combinational op application: word, imm, op -> result).

Test Plan:
- MOVI id=5 imm=0x10 into an idle buffer -> lkup_vld stays 0; out_vld at cycle 1 with id=5, word=0x10.
- ADDI id=3 imm=2, TBL returns 0xFFFFFFFF -> lkup_id=3, tag=0; out_word=0x00000001 (wrap).
- ADDI id=7 then SUBI id=7 back-to-back -> second cmd_accept=0 until the first retires. With the macro defined, stall_cnt equals the stalled cycles.
- 17 ADDIs to distinct ids with TBL holding back responses -> accepts 16, cmd_accept=0 on the 17th. Out-of-order responses (tags 15..0) -> outputs still in issue order.
- MOVI interleaved with NOP under lkup_accept=0 -> issue pointer skips the MOVI slot, but the MOVI result waits behind the older NOP at retire.
- Assert rst with 8 slots in flight, then a late rsp for tag 2 -> all outputs 0, response ignored, next command gets tag 0.
